// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector with a loadable PAT_LEN-bit pattern and a saturating match counter.
// Latency: match rises on the clock edge that consumes the final pattern bit, so it is seen one cycle after that bit is presented.
// Backpressure: none. din is consumed on every cycle where in_valid=1. clear and pat_load pre-empt consumption for that cycle.
// Ports:
//   clk, reset     : single rising-edge clock; asynchronous active-high reset
//   din, in_valid  : serial data bit and its qualifier
//   overlap_en     : 1 = matches may share bits; 0 = history restarts after a match
//   pat_load/pat_in: strobe that latches a new pattern (MSB = first bit received)
//   clear          : synchronous clear of history, match and counter (the pattern is kept)
//   match          : registered one-cycle pulse per detected match
//   match_count    : registered saturating match count
module seq_detector_param #(
  parameter int                 PAT_LEN   = 3,
  parameter int                 CNT_W     = 8,
  parameter logic [PAT_LEN-1:0] RESET_PAT = 3'b101
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               din,
  input  logic               in_valid,
  input  logic               overlap_en,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
  input  logic               clear,
  output logic               match,
  output logic [CNT_W-1:0]   match_count
);

  localparam int                FILL_W   = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);

  logic [PAT_LEN-1:0] r_pat;
  logic [PAT_LEN-2:0] r_hist;
  logic [FILL_W-1:0]  r_fill;
  logic               r_match;
  logic [CNT_W-1:0]   r_count;

  logic [PAT_LEN-1:0] w_pat_nxt;
  logic [PAT_LEN-2:0] w_hist_nxt;
  logic [FILL_W-1:0]  w_fill_nxt;
  logic               w_match_nxt;
  logic [CNT_W-1:0]   w_count_nxt;
  logic [PAT_LEN-1:0] w_cand;
  logic               w_hit;

  // The candidate word is the stored history with the incoming bit appended as the LSB.
  assign w_cand = {r_hist, din};

  always_comb begin
    w_pat_nxt   = r_pat;
    w_hist_nxt  = r_hist;
    w_fill_nxt  = r_fill;
    w_count_nxt = r_count;
    w_hit       = 1'b0;

    if (clear) begin
      w_hist_nxt  = '0;
      w_fill_nxt  = '0;
      w_count_nxt = '0;
    end else if (pat_load) begin
      w_pat_nxt  = pat_in;
      w_hist_nxt = '0;
      w_fill_nxt = '0;
    end else if (in_valid) begin
      // Compare only once PAT_LEN-1 earlier bits are present.
      // A partially filled history can never match.
      w_hit      = (r_fill == FILL_MAX) && (w_cand == r_pat);
      w_hist_nxt = w_cand[PAT_LEN-2:0];
      if (w_hit) begin
        // In non-overlap mode, the next match needs PAT_LEN fresh bits.
        w_fill_nxt = overlap_en ? FILL_MAX : '0;
        if (!(&r_count)) begin
          w_count_nxt = r_count + 1'b1;
        end
      end else if (r_fill != FILL_MAX) begin
        w_fill_nxt = r_fill + 1'b1;
      end
    end

    w_match_nxt = w_hit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pat   <= RESET_PAT;
      r_hist  <= '0;
      r_fill  <= '0;
      r_match <= 1'b0;
      r_count <= '0;
    end else begin
      r_pat   <= w_pat_nxt;
      r_hist  <= w_hist_nxt;
      r_fill  <= w_fill_nxt;
      r_match <= w_match_nxt;
      r_count <= w_count_nxt;
    end
  end

  assign match       = r_match;
  assign match_count = r_count;

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       din = 1'b0;
  logic       in_valid = 1'b0;
  logic       overlap_en = 1'b1;
  logic       pat_load = 1'b0;
  logic [2:0] pat_in = 3'b000;
  logic       clear = 1'b0;

  logic       match_a;
  logic [7:0] count_a;
  logic       match_b;
  logic [1:0] count_b;

  int checks = 0;
  int errors = 0;

  // Behavioural model: a list of accepted bits since the last restart, plus the current pattern.
  logic       mq[$];
  logic [2:0] mpat = 3'b101;
  logic       exp_match = 1'b0;
  int         exp_cnt_a = 0;
  int         exp_cnt_b = 0;

  always #5 clk = ~clk;

  seq_detector_param #(.PAT_LEN(3), .CNT_W(8), .RESET_PAT(3'b101)) u_dut_a (
    .clk(clk), .reset(reset), .din(din), .in_valid(in_valid), .overlap_en(overlap_en),
    .pat_load(pat_load), .pat_in(pat_in), .clear(clear),
    .match(match_a), .match_count(count_a)
  );

  seq_detector_param #(.PAT_LEN(3), .CNT_W(2), .RESET_PAT(3'b101)) u_dut_b (
    .clk(clk), .reset(reset), .din(din), .in_valid(in_valid), .overlap_en(overlap_en),
    .pat_load(pat_load), .pat_in(pat_in), .clear(clear),
    .match(match_b), .match_count(count_b)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drv(input logic d, input logic v, input logic c, input logic pl,
                     input logic [2:0] pi, input logic rs);
    @(negedge clk);
    din = d; in_valid = v; clear = c; pat_load = pl; pat_in = pi; reset = rs;
  endtask

  task automatic bit_in(input logic d);
    drv(d, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
  endtask

  // The model updates on each rising edge from the inputs held across it.
  // The DUTs are then compared slightly after the edge.
  always @(posedge clk) begin
    logic [2:0] w;
    logic       hit;
    if (reset) begin
      mq.delete(); mpat = 3'b101; exp_match = 1'b0; exp_cnt_a = 0; exp_cnt_b = 0;
    end else if (clear) begin
      mq.delete(); exp_match = 1'b0; exp_cnt_a = 0; exp_cnt_b = 0;
    end else if (pat_load) begin
      mq.delete(); mpat = pat_in; exp_match = 1'b0;
    end else if (in_valid) begin
      mq.push_back(din);
      hit = 1'b0;
      if (mq.size() >= 3) begin
        for (int i = 0; i < 3; i++) w[i] = mq[mq.size() - 1 - i];
        hit = (w == mpat);
      end
      exp_match = hit;
      if (hit) begin
        if (exp_cnt_a < 255) exp_cnt_a++;
        if (exp_cnt_b < 3) exp_cnt_b++;
        if (!overlap_en) mq.delete();
      end
      while (mq.size() > 3) void'(mq.pop_front());
    end else begin
      exp_match = 1'b0;
    end
    #1;
    check("match_a", int'(match_a), int'(exp_match));
    check("count_a", int'(count_a), exp_cnt_a);
    check("match_b", int'(match_b), int'(exp_match));
    check("count_b", int'(count_b), exp_cnt_b);
  end

  initial begin
    #1;
    check("reset_match", int'(match_a), 0);
    check("reset_count", int'(count_a), 0);
    drv(0, 0, 0, 0, 3'b000, 1'b1);
    idle();

    // Default pattern 101, overlap on: 1,0,1,0,1 gives two matches.
    overlap_en = 1'b1;
    bit_in(1); bit_in(0); bit_in(1); bit_in(0);
    check("t1_match_after_bit3", int'(match_a), 1);
    bit_in(1); idle();
    check("t1_match_after_bit5", int'(match_a), 1);
    check("t1_count", int'(count_a), 2);
    check("t1_model_count", exp_cnt_a, 2);

    // Same stream with overlap off gives a single match.
    drv(0, 0, 1, 0, 3'b000, 0);
    overlap_en = 1'b0;
    bit_in(1); bit_in(0); bit_in(1); bit_in(0); bit_in(1); idle();
    check("t2_match_bit5", int'(match_a), 0);
    check("t2_count", int'(count_a), 1);
    check("t2_model_count", exp_cnt_a, 1);

    // Gaps in in_valid do not break the pattern.
    drv(0, 0, 1, 0, 3'b000, 0);
    overlap_en = 1'b1;
    bit_in(1); idle(); idle(); idle();
    check("t3_idle_match", int'(match_a), 0);
    bit_in(0); idle(); bit_in(1); idle();
    check("t3_match", int'(match_a), 1);
    check("t3_count", int'(count_a), 1);

    // Loading a new pattern discards the history.
    drv(0, 0, 1, 0, 3'b000, 0);
    bit_in(1); bit_in(0);
    drv(0, 0, 0, 1, 3'b110, 0);
    bit_in(1); bit_in(1); bit_in(0); idle();
    check("t4_match_110", int'(match_a), 1);
    check("t4_count", int'(count_a), 1);
    bit_in(1); bit_in(0); bit_in(1); idle();
    check("t4_no_101", int'(match_a), 0);
    check("t4_count_hold", int'(count_a), 1);

    // The narrow counter saturates at 3, and clear keeps the pattern.
    drv(0, 0, 0, 0, 3'b000, 1'b1);
    idle();
    for (int i = 0; i < 9; i++) bit_in(logic'(~i[0]));
    idle();
    check("t5_count_b_sat", int'(count_b), 3);
    check("t5_count_a", int'(count_a), 4);
    idle();
    check("t5_count_b_hold", int'(count_b), 3);
    drv(0, 0, 1, 0, 3'b000, 0);
    idle();
    check("t5_count_b_clear", int'(count_b), 0);
    bit_in(1); bit_in(0); bit_in(1); idle();
    check("t5_pat_kept", int'(match_b), 1);

    // Reset in the middle of a pattern discards the partial history.
    bit_in(1); bit_in(0);
    drv(0, 0, 0, 0, 3'b000, 1'b1);
    bit_in(1); idle();
    check("t6_no_match", int'(match_a), 0);
    bit_in(0); bit_in(1); idle();
    check("t6_match", int'(match_a), 1);
    check("t6_count", int'(count_a), 1);

    // Randomised traffic, checked against the model on every cycle.
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 199));
      if (r < 1)       drv(0, 0, 0, 0, 3'b000, 1'b1);
      else if (r < 5)  drv(0, 0, 1, 0, 3'b000, 0);
      else if (r < 11) drv(0, 0, 0, 1, 3'($urandom_range(0, 7)), 0);
      else drv(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 3) != 0), 0, 0, 3'b000, 0);
      if ($urandom_range(0, 15) == 0) overlap_en = ~overlap_en;
    end
    idle(); idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
